// File: rtl/fb_rect_writer_if.sv
// Command channel for fb_rect_writer: one rectangle-fill request
// per valid/ready handshake.
interface fb_rect_writer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_x;
    logic [6:0] cmd_y;
    logic [7:0] cmd_w;
    logic [6:0] cmd_h;
    logic [5:0] cmd_color;

    modport master (
        output cmd_valid,
        output cmd_x,
        output cmd_y,
        output cmd_w,
        output cmd_h,
        output cmd_color,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_x,
        input  cmd_y,
        input  cmd_w,
        input  cmd_h,
        input  cmd_color,
        output cmd_ready
    );
endinterface

// File: rtl/fb_rect_writer.sv
// Rectangle-fill rasteriser feeding the frame buffer write port.
// Define FB_VBLANK_GATE_EN to advance fills only while frame_blank is high.
module fb_rect_writer #(
    parameter int FIFO_DEPTH = 4,
    parameter int FB_W       = 160,
    parameter int FB_H       = 120,
    parameter int AW         = 15
) (
    input  logic          clk,
    input  logic          rst,
    fb_rect_writer_if.slave cmd,
    input  logic          frame_blank,
    output logic          write_enable,
    output logic [5:0]    din,
    output logic [AW-1:0] din_address,
    output logic          busy,
    output logic          done
);

    localparam int PW = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [7:0] w;
        logic [6:0] h;
        logic [5:0] color;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        FILL
    } state_t;

    state_t        state;
    cmd_t          mem [FIFO_DEPTH];
    cmd_t          head;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          push;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;

    logic [7:0]    x0;
    logic [7:0]    x_last;
    logic [6:0]    y_last;
    logic [5:0]    color;
    logic [7:0]    col;
    logic [6:0]    row;
    logic [AW-1:0] row_base;

    logic [8:0]    x_sum;
    logic [8:0]    x_end;
    logic [7:0]    y_sum;
    logic [7:0]    y_end;
    logic          degenerate;
    logic          last_col;
    logic          last_row;
    logic          fill_en;

    assign fifo_full  = (count == (PW+1)'(FIFO_DEPTH));
    assign fifo_empty = (count == '0);
    assign cmd.cmd_ready = ~fifo_full;
    assign push = cmd.cmd_valid & ~fifo_full;
    assign pop  = (state == LOAD);
    assign head = mem[rd_ptr];
    assign busy = (state != IDLE) | ~fifo_empty;

`ifdef FB_VBLANK_GATE_EN
    assign fill_en = frame_blank;
`else
    logic unused_blank;
    assign unused_blank = frame_blank;
    assign fill_en = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {cmd.cmd_x, cmd.cmd_y, cmd.cmd_w,
                            cmd.cmd_h, cmd.cmd_color};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

    // Wide sums so x+w / y+h clip to the screen edge instead of wrapping.
    assign x_sum = {1'b0, head.x} + {1'b0, head.w};
    assign x_end = (x_sum > 9'(FB_W)) ? 9'(FB_W) : x_sum;
    assign y_sum = {1'b0, head.y} + {1'b0, head.h};
    assign y_end = (y_sum > 8'(FB_H)) ? 8'(FB_H) : y_sum;

    assign degenerate = (head.w == '0) | (head.h == '0) |
                        ({1'b0, head.x} >= 9'(FB_W)) |
                        ({1'b0, head.y} >= 8'(FB_H));

    assign last_col = (col == x_last);
    assign last_row = (row == y_last);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            write_enable <= 1'b0;
            din          <= '0;
            din_address  <= '0;
            done         <= 1'b0;
            x0           <= '0;
            x_last       <= '0;
            y_last       <= '0;
            color        <= '0;
            col          <= '0;
            row          <= '0;
            row_base     <= '0;
        end else begin
            write_enable <= 1'b0;
            done         <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (!fifo_empty) state <= LOAD;
                end
                LOAD: begin
                    x0       <= head.x;
                    color    <= head.color;
                    x_last   <= 8'(x_end - 9'd1);
                    y_last   <= 7'(y_end - 8'd1);
                    col      <= head.x;
                    row      <= head.y;
                    row_base <= (AW'(head.y) << 7) + (AW'(head.y) << 5);
                    if (degenerate) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        state <= FILL;
                    end
                end
                FILL: begin
                    if (fill_en) begin
                        write_enable <= 1'b1;
                        din          <= color;
                        din_address  <= row_base + AW'(col);
                        if (last_col) begin
                            col      <= x0;
                            row      <= row + 7'd1;
                            row_base <= row_base + AW'(FB_W);
                            if (last_row) begin
                                done  <= 1'b1;
                                state <= fifo_empty ? IDLE : LOAD;
                            end
                        end else begin
                            col <= col + 8'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fb_rect_writer.sv
// Self-checking bench for fb_rect_writer: pixel-list model plus
// literal latency and address checks.
module tb_fb_rect_writer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        frame_blank = 1'b1;
    logic        write_enable;
    logic [5:0]  din;
    logic [14:0] din_address;
    logic        busy;
    logic        done;

    fb_rect_writer_if cif ();

    fb_rect_writer #(
        .FIFO_DEPTH(4),
        .FB_W(160),
        .FB_H(120),
        .AW(15)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cmd(cif),
        .frame_blank(frame_blank),
        .write_enable(write_enable),
        .din(din),
        .din_address(din_address),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int pix_addr_q[$];
    int pix_col_q[$];
    int npix_q[$];
    int got_q[$];
    int eq[$];
    int done_cnt = 0;
    int cur_rem = 0;
    logic fb_q = 1'b1;

    always @(posedge clk) fb_q <= frame_blank;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference: every pixel of the clipped rectangle, row-major.
    task automatic model_add(input int x, input int y, input int w,
                             input int h, input int c);
        int n = 0;
        int xe = (x + w < 160) ? x + w : 160;
        int ye = (y + h < 120) ? y + h : 120;
        if (w > 0 && h > 0 && x < 160 && y < 120) begin
            for (int r = y; r < ye; r++) begin
                for (int cc = x; cc < xe; cc++) begin
                    pix_addr_q.push_back(r * 160 + cc);
                    pix_col_q.push_back(c);
                    n++;
                end
            end
        end
        npix_q.push_back(n);
    endtask

    initial begin
        int n;
        int a;
        int c;
        forever begin
            @(negedge clk);
            if (!rst) begin
                pix_addr_q.delete();
                pix_col_q.delete();
                npix_q.delete();
                cur_rem = 0;
            end else if (write_enable) begin
                if (cur_rem == 0) begin
                    chk("cmd_pending", int'(npix_q.size() > 0), 1);
                    if (npix_q.size() > 0) begin
                        n = npix_q.pop_front();
                        chk("cmd_has_pixels", int'(n > 0), 1);
                        cur_rem = n;
                    end
                end
                if (cur_rem > 0) begin
                    a = pix_addr_q.pop_front();
                    c = pix_col_q.pop_front();
                    chk("pix_addr", int'(din_address), a);
                    chk("pix_din", int'(din), c);
                    cur_rem--;
                    chk("done_on_last", int'(done), int'(cur_rem == 0));
                end
                chk("addr_in_range", int'(din_address < 15'd19200), 1);
                got_q.push_back(int'(din_address));
                if (done) done_cnt++;
            end else begin
                if (cur_rem > 0 && fb_q)
                    chk("no_gap", int'(write_enable), 1);
                if (done) begin
                    done_cnt++;
                    chk("degen_pending",
                        int'(cur_rem == 0 && npix_q.size() > 0), 1);
                    if (cur_rem == 0 && npix_q.size() > 0) begin
                        n = npix_q.pop_front();
                        chk("degen_npix", n, 0);
                    end
                end
            end
        end
    end

    task automatic push(input int x, input int y, input int w,
                        input int h, input int c);
        int t = 0;
        @(negedge clk);
        while (!cif.cmd_ready && t < 30000) begin
            @(negedge clk);
            t++;
        end
        chk("push_ready", int'(cif.cmd_ready), 1);
        cif.cmd_valid = 1'b1;
        cif.cmd_x     = 8'(x);
        cif.cmd_y     = 7'(y);
        cif.cmd_w     = 8'(w);
        cif.cmd_h     = 7'(h);
        cif.cmd_color = 6'(c);
        @(posedge clk);
        model_add(x, y, w, h, c);
        #1 cif.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        @(negedge clk);
        while ((busy || npix_q.size() != 0 || pix_addr_q.size() != 0 ||
                cur_rem != 0) && t < 30000) begin
            @(negedge clk);
            t++;
        end
        chk("idle_busy", int'(busy), 0);
        chk("model_drained", pix_addr_q.size() + npix_q.size(), 0);
    endtask

    task automatic check_got(input string nm, input int e[$]);
        chk({nm, "_count"}, got_q.size(), e.size());
        for (int i = 0; i < e.size() && i < got_q.size(); i++)
            chk(nm, got_q[i], e[i]);
    endtask

    initial begin
        int d0;
        cif.cmd_valid = 1'b0;
        cif.cmd_x = '0;
        cif.cmd_y = '0;
        cif.cmd_w = '0;
        cif.cmd_h = '0;
        cif.cmd_color = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_we", int'(write_enable), 0);
        chk("rst_din", int'(din), 0);
        chk("rst_addr", int'(din_address), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ready", int'(cif.cmd_ready), 1);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Single pixel: first write lands three edges after acceptance.
        got_q.delete();
        d0 = done_cnt;
        push(5, 2, 1, 1, 'h2A);
        chk("lat_busy_n", int'(busy), 1);
        @(posedge clk); #1;
        chk("lat_we_n1", int'(write_enable), 0);
        @(posedge clk); #1;
        chk("lat_we_n2", int'(write_enable), 0);
        @(posedge clk); #1;
        chk("lat_we_n3", int'(write_enable), 1);
        chk("lat_addr_n3", int'(din_address), 325);
        chk("lat_din_n3", int'(din), 'h2A);
        chk("lat_done_n3", int'(done), 1);
        @(posedge clk); #1;
        chk("lat_busy_n4", int'(busy), 0);
        chk("lat_we_n4", int'(write_enable), 0);
        chk("lat_done_n4", int'(done), 0);
        wait_idle();
        chk("single_done", done_cnt - d0, 1);

        got_q.delete();
        d0 = done_cnt;
        push(10, 0, 3, 2, 'h15);
        wait_idle();
        eq = '{10, 11, 12, 170, 171, 172};
        check_got("rect_addr", eq);
        chk("rect_done", done_cnt - d0, 1);

        got_q.delete();
        d0 = done_cnt;
        push(158, 118, 4, 4, 'h33);
        wait_idle();
        eq = '{19038, 19039, 19198, 19199};
        check_got("clip_addr", eq);
        chk("clip_done", done_cnt - d0, 1);

        got_q.delete();
        d0 = done_cnt;
        push(20, 20, 0, 5, 'h01);
        push(160, 10, 3, 3, 'h02);
        push(0, 0, 2, 1, 'h3F);
        wait_idle();
        eq = '{0, 1};
        check_got("degen_addr", eq);
        chk("degen_done", done_cnt - d0, 3);

        // Long fill keeps the engine busy while the FIFO fills behind it.
        got_q.delete();
        d0 = done_cnt;
        push(0, 0, 160, 120, 'h05);
        repeat (3) @(posedge clk);
        for (int i = 0; i < 4; i++)
            push(i * 10, 50, 2, 1, i + 1);
        chk("full_ready", int'(cif.cmd_ready), 0);
        chk("full_busy", int'(busy), 1);
        push(40, 50, 2, 1, 5);
        wait_idle();
        chk("full_done", done_cnt - d0, 6);
        chk("full_count", got_q.size(), 19210);
        if (got_q.size() > 0)
            chk("full_tail", got_q[got_q.size() - 1], 8041);

        got_q.delete();
        d0 = done_cnt;
        push(100, 60, 4, 2, 'h0C);
        repeat (3) @(negedge clk);
        frame_blank = 1'b0;
        repeat (3) @(negedge clk);
        frame_blank = 1'b1;
        @(negedge clk);
        frame_blank = 1'b0;
        repeat (2) @(negedge clk);
        frame_blank = 1'b1;
        wait_idle();
        eq = '{9700, 9701, 9702, 9703, 9860, 9861, 9862, 9863};
        check_got("blank_addr", eq);
        chk("blank_done", done_cnt - d0, 1);

        push(30, 40, 20, 20, 'h11);
        repeat (50) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("mid_rst_we", int'(write_enable), 0);
        chk("mid_rst_done", int'(done), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_ready", int'(cif.cmd_ready), 1);
        chk("mid_rst_addr", int'(din_address), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        got_q.delete();
        push(1, 1, 2, 2, 'h3F);
        wait_idle();
        eq = '{161, 162, 321, 322};
        check_got("post_rst_addr", eq);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/fb_rect_writer.md
Name: fb_rect_writer

Overview:
Upstream feeder for the VGA frame buffer write port of the 160x120 (6-bit RGB) display.
- Accepts rectangle-fill commands (x, y, w, h, colour) through a valid/ready handshake and buffers them in a small command FIFO.
- Rasterises each command into per-pixel writes: write_enable / din / din_address, at one pixel per clock.
- Used by the game logic to draw blocks, the player and the background without per-pixel sequencing.

Parameters:
FIFO_DEPTH, 4, command FIFO entries; power of two, minimum 2
FB_W, 160, frame buffer width in pixels
FB_H, 120, frame buffer height in pixels
AW, 15, frame buffer address width; must satisfy 2^AW >= FB_W*FB_H

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  FIFO can accept a command
cmd_x  in  8  left column, 0..159
cmd_y  in  7  top row, 0..119
cmd_w  in  8  width in pixels
cmd_h  in  7  height in pixels
cmd_color  in  6  RGB fill value
frame_blank  in  1  vertical-blank window from the display timing; used only with the optional feature
write_enable  out  1  frame buffer write strobe, one pixel per cycle
din  out  6  pixel data
din_address  out  AW  pixel address, y*160+x; the frame buffer write port is AW bits wide
busy  out  1  FIFO not empty or a fill is in progress
done  out  1  one-cycle pulse per retired command

Behaviour:
- Reset (rst low, asynchronous): FIFO emptied, state IDLE. write_enable=0, din=0, din_address=0, done=0, busy=0, cmd_ready=1. Any fill in progress is abandoned with no further writes.
- Handshake: a command is pushed on a rising edge with cmd_valid & cmd_ready. cmd_ready = ~fifo_full only; it is not combinationally dependent on cmd_valid. A pop and a push in the same cycle are both honoured.
- All outputs are registered.
- FSM states:
  - IDLE: if the FIFO is non-empty, go to LOAD.
  - LOAD: pop the head entry and latch it. Clip: x_end = min(x+w, FB_W), y_end = min(y+h, FB_H), computed with 9-bit/8-bit sums, so there is no wrap.
    - If w==0, h==0, x>=FB_W or y>=FB_H: pulse done, perform no writes, return to IDLE.
    - Otherwise set col=x, row=y, row_base=(y<<7)+(y<<5) (no multiplier), and go to FILL.
  - FILL: each enabled cycle registers write_enable=1, din=colour, din_address=row_base+col.
    - If col==x_end-1: col<=x, row<=row+1, row_base<=row_base+160.
    - Otherwise col<=col+1.
    - On the last pixel (col==x_end-1 and row==y_end-1): done pulses coincident with the final write; next state is LOAD if the FIFO is non-empty, else IDLE.
- Latency: with an empty FIFO in IDLE, a command accepted at edge N gives its first write_enable at edge N+3. N+1 is IDLE->LOAD, N+2 is LOAD->FILL, N+3 is the first registered write.
- Throughput: 1 pixel/clock. Back-to-back commands cost 1 LOAD cycle between them.
- write_enable is low in every cycle not producing a pixel. din and din_address hold their last value when write_enable is low.
- busy = (state!=IDLE) | ~fifo_empty.
- Overlapping rectangles are written in command order; the later command wins.
- FIFO occupancy counter is log2(FIFO_DEPTH)+1 bits; read and write pointers wrap modulo FIFO_DEPTH.

Optional Feature:
FB_VBLANK_GATE_EN
- Defined: in FILL, a pixel is written and the counters advance only in cycles where frame_blank is high. When frame_blank is low, write_enable=0 and col/row/row_base hold. Filling resumes exactly where it stopped, giving tear-free updates. LOAD and FIFO pushes are unaffected.
- Not defined: frame_blank is ignored and FILL advances every cycle.

Test Plan:
- Single pixel x=5, y=2, w=1, h=1, colour 0x2A, pushed at edge N -> exactly one write: din_address=325, din=0x2A at edge N+3; done high in that same cycle; busy low the cycle after.
- Rect x=10, y=0, w=3, h=2, colour 0x15 -> six consecutive writes to addresses 10, 11, 12, 170, 171, 172; write_enable never drops between them.
- Clipping: x=158, y=118, w=4, h=4 -> only addresses 19038, 19039, 19198, 19199 written; done once; no address >= 19200 ever appears.
- Degenerate: w=0 (and separately x=160) -> no write_enable; done pulses once; the next queued command executes normally.
- FIFO full: hold the engine busy with a 160x120 fill and push 5 further commands -> cmd_ready low after the 4th queued entry; no entry lost or duplicated; all 5 complete in order with 5 further done pulses.
- Reset mid-fill (rst low during a 20x20 fill) -> write_enable, done and busy go 0 immediately; cmd_ready=1. After release, a new command writes from its own origin. With FB_VBLANK_GATE_EN: toggling frame_blank pauses and resumes the fill with no skipped or repeated address.
